pe_inst_sequencer: RTL

- Program sequencer for one PE control/DSP slice. Holds a small instruction memory loaded by the host.
- On start, it issues the stored 64-bit instructions, one per cycle, into the PE control decoder. It counts the compute instructions it issued and the dout_v results that come back.
- It pulses done once every issued compute op has retired, or flags an error on a timeout.

---
 rtl/pe_inst_sequencer_pkg.sv | 31 +++
 rtl/pe_inst_sequencer_seq_imem.sv | 24 ++
 rtl/pe_inst_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pe_inst_sequencer_pkg.sv
// Shared types and constants for the PE instruction sequencer.
// Optional feature macro: SEQ_LOOP_EN (program repeat count).
package pe_inst_sequencer_pkg;

  localparam int INST_WIDTH = 64;
  localparam int OPC_HI     = 26;
  localparam int OPC_LO     = 24;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b101;
  localparam logic [2:0] OP_SUBI = 3'b110;
  localparam logic [2:0] OP_MULI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Same rule the PE decoder uses to decide a word produces a result.
  function automatic logic is_compute(
    input logic [INST_WIDTH-1:0] w
  );
    return w[OPC_HI:OPC_LO] != OP_LOAD;
  endfunction

endpackage

// File: rtl/pe_inst_sequencer_seq_imem.sv
// Instruction memory: sync write, async read.
// No reset; contents survive rst_n.
module seq_imem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pe_inst_sequencer.sv
// Issues stored instructions to the PE decoder and tracks retirement.
// Define SEQ_LOOP_EN to add the loop_cnt repeat input.
module pe_inst_sequencer
  import pe_inst_sequencer_pkg::*;
#(
  parameter int IMEM_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int PIPE_DELAY = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  prog_we,
  input  logic [ADDR_W-1:0]     prog_addr,
  input  logic [INST_WIDTH-1:0] prog_data,
  input  logic [ADDR_W:0]       prog_len,
  input  logic                  start,
  input  logic                  hold,
  input  logic                  dout_v,
`ifdef SEQ_LOOP_EN
  input  logic [7:0]            loop_cnt,
`endif
  output logic [INST_WIDTH-1:0] inst,
  output logic                  inst_v,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [7:0] WD_LAST = 8'(PIPE_DELAY + 3);

  seq_state_e state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [ADDR_W:0]       len_q, len_d;
  logic [CNT_W-1:0]      issued_q, issued_d;
  logic [CNT_W-1:0]      retired_q, retired_d;
  logic [7:0]            drain_q, drain_d;
  logic                  err_q, err_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  inst_v_q, inst_v_d;
  logic [INST_WIDTH-1:0] rdata;
  logic                  last;
`ifdef SEQ_LOOP_EN
  logic [7:0]            lcnt_q, lcnt_d;
  logic [7:0]            loop_q, loop_d;
`endif

  seq_imem #(
    .DEPTH (IMEM_DEPTH),
    .AW    (ADDR_W),
    .W     (INST_WIDTH)
  ) u_imem (
    .clk   (clk),
    .we    (prog_we && state_q == ST_IDLE),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (rdata)
  );

  assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign last = {1'b0, pc_q} == len_q - 1'b1;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    len_d     = len_q;
    issued_d  = issued_q;
    retired_d = retired_q;
    drain_d   = drain_q;
    err_d     = err_q;
    inst_d    = '0;
    inst_v_d  = 1'b0;
`ifdef SEQ_LOOP_EN
    lcnt_d    = lcnt_q;
    loop_d    = loop_q;
`endif
    if (busy && dout_v && retired_q != '1)
      retired_d = retired_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d     = prog_len;
          pc_d      = '0;
          issued_d  = '0;
          retired_d = '0;
          drain_d   = '0;
          err_d     = 1'b0;
`ifdef SEQ_LOOP_EN
          lcnt_d    = loop_cnt;
          loop_d    = '0;
`endif
          state_d   = (prog_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (!hold) begin
          inst_d   = rdata;
          inst_v_d = 1'b1;
          pc_d     = pc_q + 1'b1;
          if (is_compute(rdata) && issued_q != '1)
            issued_d = issued_q + 1'b1;
          if (last) begin
`ifdef SEQ_LOOP_EN
            if (loop_q < lcnt_q) begin
              pc_d   = '0;
              loop_d = loop_q + 1'b1;
            end else begin
              state_d = ST_DRAIN;
            end
`else
            state_d = ST_DRAIN;
`endif
          end
        end
      end
      ST_DRAIN: begin
        if (retired_q == issued_q) begin
          state_d = ST_DONE;
        end else if (drain_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      drain_q   <= '0;
      err_q     <= 1'b0;
      inst_q    <= '0;
      inst_v_q  <= 1'b0;
`ifdef SEQ_LOOP_EN
      lcnt_q    <= '0;
      loop_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      drain_q   <= drain_d;
      err_q     <= err_d;
      inst_q    <= inst_d;
      inst_v_q  <= inst_v_d;
`ifdef SEQ_LOOP_EN
      lcnt_q    <= lcnt_d;
      loop_q    <= loop_d;
`endif
    end
  end

  assign inst   = inst_q;
  assign inst_v = inst_v_q;
  assign done   = state_q == ST_DONE;
  assign err    = err_q;

endmodule
